// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers (reduction polynomial x^8+x^4+x^3+x+1).
package aes_pkg;

  typedef logic [0:127] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  localparam int AES_NB = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_fsm_e;

  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_byte_t gf_mul2(input aes_byte_t b);
    return xtime(b);
  endfunction

  function automatic aes_byte_t gf_mul3(input aes_byte_t b);
    return xtime(b) ^ b;
  endfunction

  // The inverse coefficients are built from b*8, b*4, b*2 and b.
  function automatic aes_byte_t gf_mul9(input aes_byte_t b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic aes_byte_t gf_mulb(input aes_byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic aes_byte_t gf_muld(input aes_byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic aes_byte_t gf_mule(input aes_byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational (Inv)MixColumns on one 32-bit column; byte 0 of the column sits in col[31:24].
module mix_column_word
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  aes_byte_t a0, a1, a2, a3;
  aes_byte_t b0, b1, b2, b3;

  assign a0 = col[31:24];
  assign a1 = col[23:16];
  assign a2 = col[15:8];
  assign a3 = col[7:0];

  always_comb begin
    b0 = '0;
    b1 = '0;
    b2 = '0;
    b3 = '0;
    if (INVERSE) begin
      b0 = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
      b1 = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
      b2 = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
      b3 = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);
    end else begin
      b0 = gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
      b1 = a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
      b2 = a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3);
      b3 = gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3);
    end
  end

  assign mixed = {b0, b1, b2, b3};

endmodule

// File: rtl/mix_columns_seq.sv
// Column-serial AES (Inv)MixColumns: COLS_PER_CYCLE columns rewritten in place per clock.
// Handshake: a beat transfers on a rising edge where valid & ready; out_valid is never withdrawn until out_ready.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INVERSE        = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_state_t in_state,
  input  logic       in_last_round,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_state_t out_state
);

  localparam logic [1:0] CNT_STEP  = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_BASE = 2'(AES_NB - COLS_PER_CYCLE);

  mc_fsm_e    fsm, fsm_next;
  logic [1:0] col_cnt;
  aes_state_t blk;
  logic       accept;

  logic [1:0]  col_idx [COLS_PER_CYCLE];
  logic [31:0] col_in  [COLS_PER_CYCLE];
  logic [31:0] col_out [COLS_PER_CYCLE];

  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
    assign col_idx[j] = col_cnt + 2'(j);
    assign col_in[j]  = blk[{col_idx[j], 5'd0} +: 32];

    mix_column_word #(
      .INVERSE (INVERSE)
    ) u_word (
      .col   (col_in[j]),
      .mixed (col_out[j])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= ST_IDLE;
    else        fsm <= fsm_next;
  end

  always_comb begin
    fsm_next  = fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (fsm)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_next = in_last_round ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        if (col_cnt == LAST_BASE) fsm_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        // Handing off and accepting the next block share one edge.
        if (out_ready) begin
          if (in_valid) fsm_next = in_last_round ? ST_DONE : ST_BUSY;
          else          fsm_next = ST_IDLE;
        end
      end
      default: fsm_next = ST_IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk     <= '0;
      col_cnt <= '0;
    end else if (accept) begin
      blk     <= in_state;
      col_cnt <= '0;
    end else if (fsm == ST_BUSY) begin
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
        blk[{col_idx[j], 5'd0} +: 32] <= col_out[j];
      end
      // The last busy edge wraps the counter back to column 0.
      col_cnt <= col_cnt + CNT_STEP;
    end
  end

  assign out_state = blk;

endmodule
